cde_ctrl: RTL and testbench
===========================

CDE_CTRL -- requirements
Module: cde_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, sets the CAM/flash slot address width; the slot count is 2**ADDR_WIDTH.
REQ-002 Parameter AES_TMO, default 64, is the maximum cycles to wait for ready_encryption before aborting.
REQ-003 Parameter CAM_LAT, default 2, is the cycles from loading the CAM compare data to a valid match.
REQ-004 clk  in  1  is the single clock; everything is sampled on its rising edge.
REQ-005 rst  in  1  is the reset: asynchronous assert, active-low (0 = reset), released synchronously by the integrator.
REQ-006 cmd_valid in 1 requests a command; cmd_op in 2 gives the command: 00 BOOT, 01 STORE, 10 RETRIEVE, 11 reserved.
REQ-007 cmd_ready out 1 means a command is accepted on this cycle; boot_cnt in ADDR_WIDTH+1 gives the number of valid flash entries for BOOT.
REQ-008 done out 1 is a one-cycle completion pulse; status out 2 carries the result: 00 OK, 01 NOT_FOUND, 10 FULL, 11 TIMEOUT/ILLEGAL.
REQ-009 flash_rd out 1 and flash_wr out 1 are flash strobes held until flash_ack in 1 is sampled high.
REQ-010 match in 1 and ready_encryption in 1 come from the datapath.
REQ-011 The datapath strobes, all out 1, are: flash_or_acc_reg, flash_or_acc_sel, flash_acc_reg, flash_pass_reg, pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg, local_master_sel, out_reg, write_en, boot_lood.
REQ-012 write_add out ADDR_WIDTH is the CAM write / flash address; used out ADDR_WIDTH+1 is the occupied-slot count.

Function
REQ-013 The FSM states SHALL be IDLE, BT_RD, BT_LD, BT_WR, ST_LD, ST_CAM, ST_ENC, ST_WR, RT_LD, RT_CMP, RT_RD, RT_DEC, RT_ENC, RT_OUT and FIN.
REQ-014 cmd_ready SHALL be high only in IDLE; a command SHALL start on the cycle where cmd_valid and cmd_ready are both high; cmd_op is sampled only on that cycle.
REQ-015 Reserved cmd_op SHALL go directly to FIN with status 11.
REQ-016 BOOT SHALL, for i = 0..boot_cnt-1:
  - BT_RD: write_add=i, boot_lood=0, flash_rd=1 until flash_ack.
  - BT_LD: flash_or_acc_sel=0, flash_or_acc_reg=1.
  - BT_WR: write_en=1, write_add=i.
REQ-017 BOOT SHALL then set used=boot_cnt; boot_cnt=0 SHALL finish immediately with OK; boot_cnt above 2**ADDR_WIDTH SHALL be clamped to 2**ADDR_WIDTH.
REQ-018 STORE with used = 2**ADDR_WIDTH SHALL go to FIN with status 10 and issue no strobes.
REQ-019 STORE SHALL otherwise run:
  - ST_LD: flash_or_acc_sel=1, flash_or_acc_reg=1, new_old_pass_sel=0, plain_reg=1, local_master_sel=0, local_master_reg=1.
  - ST_CAM: flash_acc_reg=1, write_en=1, write_add=used, boot_lood=0.
REQ-020 ST_ENC SHALL wait for ready_encryption, ignoring its value on the first ST_ENC cycle; on ready it SHALL pulse flash_pass_reg; after AES_TMO cycles without ready it SHALL go to FIN with status 11.
REQ-021 ST_WR SHALL hold flash_wr=1 and write_add=used until flash_ack, then increment used and go to FIN with status 00.
REQ-022 RETRIEVE SHALL run:
  - RT_LD: flash_or_acc_sel=1, flash_or_acc_reg=1.
  - RT_CMP: wait CAM_LAT cycles, then sample match; match=0 SHALL go to FIN with status 01.
REQ-023 RETRIEVE SHALL continue:
  - RT_RD: boot_lood=1, flash_rd=1 until flash_ack, pulse pass_enc_reg on the ack cycle.
  - RT_DEC: new_old_pass_sel=1, plain_reg=1, local_master_sel=1, local_master_reg=1.
REQ-024 RT_ENC SHALL follow the REQ-020 wait and timeout rules; on ready, RT_OUT SHALL pulse out_reg for one cycle, then FIN with status 00.
REQ-025 FIN SHALL pulse done for exactly one cycle, hold status until the next command starts, and return to IDLE.
REQ-026 Every strobe not named for a state SHALL be 0 in that state; the *_reg strobes, write_en and done SHALL be one-cycle pulses.
REQ-027 flash_rd and flash_wr SHALL never be high together; flash_ack outside BT_RD, ST_WR and RT_RD SHALL be ignored.

Reset
REQ-028 While rst=0, every output SHALL be 0 and the FSM SHALL be in IDLE; cmd_ready SHALL rise on the first clock after release.
REQ-029 Reset mid-operation SHALL abort the operation, drop any in-flight strobe asynchronously, clear used to 0, and produce no done pulse.

Verification
REQ-030 BOOT with boot_cnt=3 and flash_ack one cycle after each flash_rd -> write_en pulses with write_add=0,1,2, used=3, done with status 00.
REQ-031 STORE with used=3 and ready_encryption 5 cycles after ST_ENC -> write_en at write_add=3, then flash_pass_reg, then flash_wr at write_add=3, used=4, status 00.
REQ-032 RETRIEVE with match=1 -> boot_lood=1 during flash_rd, pass_enc_reg, then the RT_DEC strobes, one out_reg pulse, status 00; with match=0 -> status 01 and no flash_rd.
REQ-033 STORE with used=16 -> status 10 and no write_en or flash_wr; ready_encryption held 0 -> status 11 after 64 cycles.
REQ-034 rst pulled low during ST_WR with flash_wr high -> flash_wr drops immediately, used=0, no done, and cmd_ready=1 one cycle after release.

Source files
------------

// File: rtl/cde_ctrl_if.sv
// Command handshake and flash bus between the key-management sequencer and its environment.
// The master side issues commands and answers the flash; the slave side is cde_ctrl.
interface cde_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic                  cmd_ready;
  logic [ADDR_WIDTH:0]   boot_cnt;
  logic                  done;
  logic [1:0]            status;
  logic                  flash_rd;
  logic                  flash_wr;
  logic                  flash_ack;
  logic [ADDR_WIDTH-1:0] write_add;
  logic [ADDR_WIDTH:0]   used;

  modport master (
    output cmd_valid, cmd_op, boot_cnt, flash_ack,
    input  cmd_ready, done, status, flash_rd, flash_wr, write_add, used
  );

  modport slave (
    input  cmd_valid, cmd_op, boot_cnt, flash_ack,
    output cmd_ready, done, status, flash_rd, flash_wr, write_add, used
  );
endinterface

// File: rtl/cde_ctrl.sv
// Sequencer for the CAM/flash key store: BOOT reloads the CAM from flash, STORE encrypts and
// saves a new entry, RETRIEVE looks one up and decrypts it. All outputs are registered.
module cde_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AES_TMO    = 64,
  parameter int CAM_LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  cde_ctrl_if.slave  bus,
  input  logic       match,
  input  logic       ready_encryption,
  output logic       flash_or_acc_reg,
  output logic       flash_or_acc_sel,
  output logic       flash_acc_reg,
  output logic       flash_pass_reg,
  output logic       pass_enc_reg,
  output logic       new_old_pass_sel,
  output logic       plain_reg,
  output logic       local_master_reg,
  output logic       local_master_sel,
  output logic       out_reg,
  output logic       write_en,
  output logic       boot_lood
);

  localparam int                  SLOTS    = 2 ** ADDR_WIDTH;
  localparam int                  CNT_W    = $clog2(AES_TMO + CAM_LAT + 1);
  localparam logic [ADDR_WIDTH:0] SLOTS_V  = (ADDR_WIDTH + 1)'(SLOTS);
  localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(AES_TMO - 1);
  localparam logic [CNT_W-1:0]    CAM_LAST = CNT_W'(CAM_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, BT_RD, BT_LD, BT_WR, ST_LD, ST_CAM, ST_ENC, ST_WR,
    RT_LD, RT_CMP, RT_RD, RT_DEC, RT_ENC, RT_OUT, FIN
  } state_t;

  state_t                state;
  state_t                nxt;
  logic [ADDR_WIDTH:0]   used_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   idx_nxt;
  logic [ADDR_WIDTH:0]   boot_total;
  logic [ADDR_WIDTH:0]   boot_clamped;
  logic [CNT_W-1:0]      wait_cnt;
  logic [1:0]            fin_status;
  logic [1:0]            status_q;
  logic                  cmd_ready_q;
  logic                  done_q;
  logic                  flash_rd_q;
  logic                  flash_wr_q;
  logic [ADDR_WIDTH-1:0] write_add_q;
  logic                  accept;
  logic                  enc_ready;
  logic                  enc_tmo;
  logic                  cam_done;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.flash_rd  = flash_rd_q;
  assign bus.flash_wr  = flash_wr_q;
  assign bus.write_add = write_add_q;
  assign bus.used      = used_q;

  // cmd_ready_q gates acceptance so the first edge after reset release cannot take a command.
  assign accept       = (state == IDLE) && bus.cmd_valid && cmd_ready_q;
  assign boot_clamped = (bus.boot_cnt > SLOTS_V) ? SLOTS_V : bus.boot_cnt;
  assign enc_ready    = (wait_cnt != '0) && ready_encryption;
  assign enc_tmo      = (wait_cnt == TMO_LAST);
  assign cam_done     = (wait_cnt == CAM_LAST);

  always_comb begin
    nxt        = state;
    fin_status = 2'b00;
    idx_nxt    = idx_q;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (accept) begin
          case (bus.cmd_op)
            2'b00: nxt = (bus.boot_cnt == '0) ? FIN : BT_RD;
            2'b01: begin
              if (used_q == SLOTS_V) begin
                nxt        = FIN;
                fin_status = 2'b10;
              end else begin
                nxt = ST_LD;
              end
            end
            2'b10: nxt = RT_LD;
            default: begin
              nxt        = FIN;
              fin_status = 2'b11;
            end
          endcase
        end
      end
      BT_RD: if (bus.flash_ack) nxt = BT_LD;
      BT_LD: nxt = BT_WR;
      BT_WR: begin
        idx_nxt = idx_q + 1'b1;
        nxt     = (idx_nxt == boot_total) ? FIN : BT_RD;
      end
      ST_LD:  nxt = ST_CAM;
      ST_CAM: nxt = ST_ENC;
      ST_ENC: begin
        if (enc_ready) begin
          nxt = ST_WR;
        end else if (enc_tmo) begin
          nxt        = FIN;
          fin_status = 2'b11;
        end
      end
      ST_WR:  if (bus.flash_ack) nxt = FIN;
      RT_LD:  nxt = RT_CMP;
      RT_CMP: begin
        if (cam_done) begin
          if (match) begin
            nxt = RT_RD;
          end else begin
            nxt        = FIN;
            fin_status = 2'b01;
          end
        end
      end
      RT_RD:  if (bus.flash_ack) nxt = RT_DEC;
      RT_DEC: nxt = RT_ENC;
      RT_ENC: begin
        if (enc_ready) begin
          nxt = RT_OUT;
        end else if (enc_tmo) begin
          nxt        = FIN;
          fin_status = 2'b11;
        end
      end
      RT_OUT: nxt = FIN;
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each strobe lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      used_q           <= '0;
      idx_q            <= '0;
      boot_total       <= '0;
      wait_cnt         <= '0;
      status_q         <= 2'b00;
      cmd_ready_q      <= 1'b0;
      done_q           <= 1'b0;
      flash_rd_q       <= 1'b0;
      flash_wr_q       <= 1'b0;
      write_add_q      <= '0;
      flash_or_acc_reg <= 1'b0;
      flash_or_acc_sel <= 1'b0;
      flash_acc_reg    <= 1'b0;
      flash_pass_reg   <= 1'b0;
      pass_enc_reg     <= 1'b0;
      new_old_pass_sel <= 1'b0;
      plain_reg        <= 1'b0;
      local_master_reg <= 1'b0;
      local_master_sel <= 1'b0;
      out_reg          <= 1'b0;
      write_en         <= 1'b0;
      boot_lood        <= 1'b0;
    end else begin
      state    <= nxt;
      idx_q    <= idx_nxt;
      wait_cnt <= ((nxt != state) || (state == IDLE)) ? '0 : wait_cnt + 1'b1;

      if (accept) boot_total <= boot_clamped;

      if ((state == BT_WR) && (nxt == FIN)) begin
        used_q <= boot_total;
      end else if (accept && (bus.cmd_op == 2'b00) && (bus.boot_cnt == '0)) begin
        used_q <= '0;
      end else if ((state == ST_WR) && bus.flash_ack) begin
        used_q <= used_q + 1'b1;
      end

      if ((nxt == FIN) && (state != FIN)) begin
        status_q <= fin_status;
      end else if (accept) begin
        status_q <= 2'b00;
      end

      cmd_ready_q <= (nxt == IDLE);
      done_q      <= (nxt == FIN);
      flash_rd_q  <= (nxt == BT_RD) || (nxt == RT_RD);
      flash_wr_q  <= (nxt == ST_WR);
      boot_lood   <= (nxt == RT_RD);

      case (nxt)
        BT_RD, BT_WR:  write_add_q <= idx_nxt[ADDR_WIDTH-1:0];
        ST_CAM, ST_WR: write_add_q <= used_q[ADDR_WIDTH-1:0];
        default:       write_add_q <= '0;
      endcase

      flash_or_acc_sel <= (nxt == ST_LD) || (nxt == RT_LD);
      flash_or_acc_reg <= (nxt == BT_LD) || (nxt == ST_LD) || (nxt == RT_LD);
      flash_acc_reg    <= (nxt == ST_CAM);
      write_en         <= (nxt == BT_WR) || (nxt == ST_CAM);
      new_old_pass_sel <= (nxt == RT_DEC);
      plain_reg        <= (nxt == ST_LD) || (nxt == RT_DEC);
      local_master_sel <= (nxt == RT_DEC);
      local_master_reg <= (nxt == ST_LD) || (nxt == RT_DEC);
      out_reg          <= (nxt == RT_OUT);

      // Event pulses: ciphertext capture on AES ready, and password capture on the flash ack.
      flash_pass_reg <= (state == ST_ENC) && (nxt == ST_WR);
      pass_enc_reg   <= (state == RT_RD) && (nxt == RT_DEC);
    end
  end

endmodule

// File: tb/tb_cde_ctrl.sv
// Directed bench for cde_ctrl: BOOT, STORE, RETRIEVE, full/timeout/reserved cases and mid-op reset.
// A flash model acks one cycle after each strobe; an AES model raises ready after ready_delay cycles.
module tb_cde_ctrl;

  logic clk;
  logic rst;
  logic match;
  logic ready_encryption;
  logic flash_or_acc_reg, flash_or_acc_sel, flash_acc_reg, flash_pass_reg;
  logic pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg;
  logic local_master_sel, out_reg, write_en, boot_lood;

  cde_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  cde_ctrl #(.ADDR_WIDTH(4), .AES_TMO(64), .CAM_LAT(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .match            (match),
    .ready_encryption (ready_encryption),
    .flash_or_acc_reg (flash_or_acc_reg),
    .flash_or_acc_sel (flash_or_acc_sel),
    .flash_acc_reg    (flash_acc_reg),
    .flash_pass_reg   (flash_pass_reg),
    .pass_enc_reg     (pass_enc_reg),
    .new_old_pass_sel (new_old_pass_sel),
    .plain_reg        (plain_reg),
    .local_master_reg (local_master_reg),
    .local_master_sel (local_master_sel),
    .out_reg          (out_reg),
    .write_en         (write_en),
    .boot_lood        (boot_lood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Environment knobs, written only by the main sequence.
  bit ack_en;
  bit ready_on;
  int ready_delay;

  // Event counters, written only by the monitor.
  int cyc = 0, n_we = 0, n_rd = 0, n_rd_lood = 0, n_wr = 0, n_both = 0;
  int n_fpr = 0, n_per = 0, n_dec = 0, n_out = 0, n_done = 0;
  int we_cyc = 0, fpr_cyc = 0, done_cyc = 0;
  logic [3:0] wr_addr = '0;
  logic [3:0] we_addr[$];

  // Snapshots, written only by the main sequence.
  int s_we, s_rd, s_rd_lood, s_wr, s_fpr, s_per, s_dec, s_out, s_done;

  logic [31:0] all_out;
  bit          ok;
  bit          got;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (write_en) begin
      n_we = n_we + 1;
      we_addr.push_back(bus.write_add);
      we_cyc = cyc;
    end
    if (bus.flash_rd) begin
      n_rd = n_rd + 1;
      if (boot_lood) n_rd_lood = n_rd_lood + 1;
    end
    if (bus.flash_wr) begin
      n_wr = n_wr + 1;
      wr_addr = bus.write_add;
    end
    if (bus.flash_rd && bus.flash_wr) n_both = n_both + 1;
    if (flash_pass_reg) begin
      n_fpr = n_fpr + 1;
      fpr_cyc = cyc;
    end
    if (pass_enc_reg) n_per = n_per + 1;
    if (new_old_pass_sel && plain_reg && local_master_sel && local_master_reg) n_dec = n_dec + 1;
    if (out_reg) n_out = n_out + 1;
    if (bus.done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
  end

  // Flash model: ack on the first cycle it sees a strobe.
  initial begin
    bus.flash_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.flash_ack = ack_en && (bus.flash_rd || bus.flash_wr);
    end
  end

  // AES model: arms on ST_CAM or RT_DEC, raises ready after ready_delay encryption cycles.
  initial begin
    int enc_cnt;
    bit enc_arm;
    ready_encryption = 1'b0;
    enc_cnt = 0;
    enc_arm = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || bus.done || flash_pass_reg || out_reg) begin
        enc_arm = 1'b0;
        ready_encryption = 1'b0;
      end else if ((write_en && flash_acc_reg) || (plain_reg && new_old_pass_sel)) begin
        enc_arm = 1'b1;
        enc_cnt = 0;
        ready_encryption = 1'b0;
      end else if (enc_arm) begin
        enc_cnt = enc_cnt + 1;
        if (ready_on && (enc_cnt >= ready_delay)) ready_encryption = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total = total + 1;
    if (got_v !== exp_v) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] cnt, output bit accepted);
    accepted = 1'b0;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.boot_cnt  = cnt;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (bus.cmd_ready) accepted = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] cnt, input int budget);
    bit acc;
    bit seen;
    applyStimulus(op, cnt, acc);
    checkOutput({tag, "_accept"}, 32'(acc), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    @(negedge clk);
    #2;
  endtask

  task automatic snap();
    s_we = n_we;  s_rd = n_rd;  s_rd_lood = n_rd_lood;  s_wr = n_wr;  s_fpr = n_fpr;
    s_per = n_per;  s_dec = n_dec;  s_out = n_out;  s_done = n_done;
  endtask

  function automatic logic [31:0] outputs_vec();
    return {5'b0, bus.cmd_ready, bus.done, bus.status, bus.flash_rd, bus.flash_wr,
            bus.write_add, bus.used, flash_or_acc_reg, flash_or_acc_sel, flash_acc_reg,
            flash_pass_reg, pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg,
            local_master_sel, out_reg, write_en, boot_lood};
  endfunction

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.boot_cnt  = '0;
    match         = 1'b0;
    ack_en        = 1'b1;
    ready_on      = 1'b1;
    ready_delay   = 5;
    #1 rst = 1'b0;

    repeat (3) @(negedge clk);
    all_out = outputs_vec();
    checkOutput("reset_outputs", all_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_release_ready", 32'(bus.cmd_ready), 32'd1);

    // BOOT of three entries
    snap();
    run_op("boot3", 2'b00, 5'd3, 40);
    checkOutput("boot3_status", 32'(bus.status), 32'd0);
    checkOutput("boot3_used", 32'(bus.used), 32'd3);
    checkOutput("boot3_we", 32'(n_we - s_we), 32'd3);
    for (int k = 0; k < 3; k++) checkOutput("boot3_addr", 32'(we_addr[s_we + k]), 32'(k));
    checkOutput("boot3_rd", 32'(n_rd - s_rd), 32'd3);
    checkOutput("boot3_done_pulses", 32'(n_done - s_done), 32'd1);

    // STORE into slot 3, ready five cycles into ST_ENC
    snap();
    ready_delay = 5;
    run_op("store", 2'b01, 5'd0, 100);
    checkOutput("store_status", 32'(bus.status), 32'd0);
    checkOutput("store_used", 32'(bus.used), 32'd4);
    checkOutput("store_we", 32'(n_we - s_we), 32'd1);
    checkOutput("store_we_addr", 32'(we_addr[s_we]), 32'd3);
    checkOutput("store_fpr", 32'(n_fpr - s_fpr), 32'd1);
    checkOutput("store_fpr_delay", 32'(fpr_cyc - we_cyc), 32'd6);
    checkOutput("store_wr", 32'(n_wr - s_wr), 32'd1);
    checkOutput("store_wr_addr", 32'(wr_addr), 32'd3);

    // RETRIEVE hit
    snap();
    match = 1'b1;
    ready_delay = 3;
    run_op("rt_hit", 2'b10, 5'd0, 100);
    checkOutput("rt_hit_status", 32'(bus.status), 32'd0);
    checkOutput("rt_hit_rd", 32'(n_rd - s_rd), 32'd1);
    checkOutput("rt_hit_rd_lood", 32'(n_rd_lood - s_rd_lood), 32'd1);
    checkOutput("rt_hit_pass_enc", 32'(n_per - s_per), 32'd1);
    checkOutput("rt_hit_dec", 32'(n_dec - s_dec), 32'd1);
    checkOutput("rt_hit_out", 32'(n_out - s_out), 32'd1);
    checkOutput("rt_hit_used", 32'(bus.used), 32'd4);

    // RETRIEVE miss
    snap();
    match = 1'b0;
    run_op("rt_miss", 2'b10, 5'd0, 40);
    checkOutput("rt_miss_status", 32'(bus.status), 32'd1);
    checkOutput("rt_miss_rd", 32'(n_rd - s_rd), 32'd0);
    checkOutput("rt_miss_out", 32'(n_out - s_out), 32'd0);

    // STORE with AES never ready
    snap();
    ready_on = 1'b0;
    run_op("st_tmo", 2'b01, 5'd0, 120);
    checkOutput("st_tmo_status", 32'(bus.status), 32'd3);
    checkOutput("st_tmo_length", 32'(done_cyc - we_cyc), 32'd65);
    checkOutput("st_tmo_wr", 32'(n_wr - s_wr), 32'd0);
    checkOutput("st_tmo_fpr", 32'(n_fpr - s_fpr), 32'd0);
    checkOutput("st_tmo_used", 32'(bus.used), 32'd4);
    ready_on = 1'b1;

    // Reset while flash_wr is held in ST_WR
    ack_en = 1'b0;
    ready_delay = 2;
    applyStimulus(2'b01, 5'd0, ok);
    checkOutput("rst_accept", 32'(ok), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.flash_wr) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rst_reach_wr", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_held", 32'(bus.flash_wr), 32'd1);
    snap();
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_wr_drop", 32'(bus.flash_wr), 32'd0);
    checkOutput("rst_used_clear", 32'(bus.used), 32'd0);
    all_out = outputs_vec();
    checkOutput("rst_outputs", all_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready_after", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_no_done", 32'(n_done - s_done), 32'd0);

    // BOOT count above the slot count is clamped
    snap();
    run_op("boot20", 2'b00, 5'd20, 200);
    checkOutput("boot20_status", 32'(bus.status), 32'd0);
    checkOutput("boot20_used", 32'(bus.used), 32'd16);
    checkOutput("boot20_we", 32'(n_we - s_we), 32'd16);
    checkOutput("boot20_last_addr", 32'(we_addr[s_we + 15]), 32'd15);

    // STORE into a full CAM
    snap();
    run_op("st_full", 2'b01, 5'd0, 20);
    checkOutput("st_full_status", 32'(bus.status), 32'd2);
    checkOutput("st_full_we", 32'(n_we - s_we), 32'd0);
    checkOutput("st_full_wr", 32'(n_wr - s_wr), 32'd0);
    checkOutput("st_full_used", 32'(bus.used), 32'd16);

    // Reserved opcode
    snap();
    run_op("resv", 2'b11, 5'd0, 20);
    checkOutput("resv_status", 32'(bus.status), 32'd3);
    checkOutput("resv_used", 32'(bus.used), 32'd16);
    checkOutput("resv_rd", 32'(n_rd - s_rd), 32'd0);

    // BOOT of zero entries
    snap();
    run_op("boot0", 2'b00, 5'd0, 20);
    checkOutput("boot0_status", 32'(bus.status), 32'd0);
    checkOutput("boot0_used", 32'(bus.used), 32'd0);
    checkOutput("boot0_rd", 32'(n_rd - s_rd), 32'd0);

    checkOutput("rd_wr_exclusive", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
